// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Program counter plus two-byte instruction register for the sequencing
//   controller. Captures opcode/operand bytes from ROM, presents the opcode
//   nibble to the controller and muxes the shared address bus between the PC
//   and the operand address.
//
// Parameters
//   ADDR_W   address width, 12 = {opcode-byte[3:0], operand-byte[7:0]}
//   RST_PC   PC value loaded on reset
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-high
//   PC_en     in   increment PC
//   pc_in     in   load PC with jump target (wins over PC_en)
//   fetch     in   01: capture opcode byte, 10: capture operand byte
//   rom_read  in   ROM data valid this cycle
//   ad_sel    in   0: addr = PC, 1: addr = operand address
//   rom_data  in   ROM read data
//   ins       out  registered opcode nibble (ir_hi[7:4])
//   addr      out  address bus to ROM/RAM
//   ir_word   out  {ir_hi, ir_lo}
//   pc        out  current PC
//   pc_ovf    out  sticky PC overflow flag (only when PC_OVF_EN is defined)
//
// Build option
//   PC_OVF_EN  when defined, an increment from the all-ones PC holds the PC
//              and sets pc_ovf; otherwise the PC wraps silently.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                ADDR_W = 12,
    parameter logic [ADDR_W-1:0] RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PC_en,
    input  logic              pc_in,
    input  logic [1:0]        fetch,
    input  logic              rom_read,
    input  logic              ad_sel,
    input  logic [7:0]        rom_data,
    output logic [3:0]        ins,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       ir_word,
    output logic [ADDR_W-1:0] pc
`ifdef PC_OVF_EN
    ,
    output logic              pc_ovf
`endif
);

    logic [7:0]        ir_hi;
    logic [7:0]        ir_lo;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] oa;
    logic [ADDR_W-1:0] jt;
    logic              capture_op;
    logic              capture_opnd;

    // An opcode fetch with ad_sel=1 is really a data read, and a jump load
    // consumes rom_data as the target byte, so neither may disturb ir_hi.
    assign capture_op   = (fetch == 2'b01) && rom_read && !ad_sel && !pc_in;
    assign capture_opnd = (fetch == 2'b10) && rom_read;

    assign oa = {ir_hi[3:0], ir_lo};
    assign jt = {ir_hi[3:0], rom_data};

`ifdef PC_OVF_EN
    logic pc_at_max;
    logic ovf_q;

    assign pc_at_max = &pc_q;

    always_comb begin
        pc_next = pc_q;
        if (pc_in) begin
            pc_next = jt;
        end else if (PC_en && !pc_at_max) begin
            pc_next = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (PC_en && !pc_in && pc_at_max) begin
            ovf_q <= 1'b1;
        end
    end

    assign pc_ovf = ovf_q;
`else
    always_comb begin
        pc_next = pc_q;
        if (pc_in) begin
            pc_next = jt;
        end else if (PC_en) begin
            pc_next = pc_q + ADDR_W'(1);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RST_PC;
            ir_hi <= 8'h00;
            ir_lo <= 8'h00;
        end else begin
            pc_q <= pc_next;
            if (capture_op) begin
                ir_hi <= rom_data;
            end
            if (capture_opnd) begin
                ir_lo <= rom_data;
            end
        end
    end

    assign ins     = ir_hi[7:4];
    assign addr    = ad_sel ? oa : pc_q;
    assign ir_word = {ir_hi, ir_lo};
    assign pc      = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        PC_en;
    logic        pc_in;
    logic [1:0]  fetch;
    logic        rom_read;
    logic        ad_sel;
    logic [7:0]  rom_data;
    logic [3:0]  ins;
    logic [11:0] addr;
    logic [15:0] ir_word;
    logic [11:0] pc;
`ifdef PC_OVF_EN
    logic        pc_ovf;
`endif

    int checks   = 0;
    int failures = 0;

    // behavioural reference state
    int m_pc;
    int m_hi;
    int m_lo;
    int m_ovf;

    typedef struct {
        logic        en;
        logic        ld;
        logic [1:0]  f;
        logic        rd;
        logic        as;
        logic [7:0]  d;
        logic [11:0] e_pc;
        logic [3:0]  e_ins;
        logic [15:0] e_word;
        logic [11:0] e_addr;
    } vec_t;

    vec_t tbl[10];
    vec_t prog[6];

    fetch_unit #(.ADDR_W(12), .RST_PC(12'h000)) dut (
        .clk      (clk),
        .rst      (rst),
        .PC_en    (PC_en),
        .pc_in    (pc_in),
        .fetch    (fetch),
        .rom_read (rom_read),
        .ad_sel   (ad_sel),
        .rom_data (rom_data),
        .ins      (ins),
        .addr     (addr),
        .ir_word  (ir_word),
        .pc       (pc)
`ifdef PC_OVF_EN
        ,
        .pc_ovf   (pc_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_hi  = 0;
        m_lo  = 0;
        m_ovf = 0;
    endtask

    // One clock edge of the specified behaviour, from the currently driven inputs.
    task automatic model_clock();
        int nhi;
        int nlo;
        int npc;
        nhi = m_hi;
        nlo = m_lo;
        npc = m_pc;
        if (fetch == 2'b01 && rom_read && !ad_sel && !pc_in) nhi = rom_data;
        if (fetch == 2'b10 && rom_read) nlo = rom_data;
        if (pc_in) begin
            npc = (m_hi % 16) * 256 + rom_data;
        end else if (PC_en) begin
`ifdef PC_OVF_EN
            if (m_pc == 4095) begin
                npc   = 4095;
                m_ovf = 1;
            end else begin
                npc = m_pc + 1;
            end
`else
            npc = (m_pc + 1) % 4096;
`endif
        end
        m_hi = nhi;
        m_lo = nlo;
        m_pc = npc;
    endtask

    task automatic drive(input logic en, input logic ld, input logic [1:0] f,
                         input logic rd, input logic as, input logic [7:0] d);
        PC_en    = en;
        pc_in    = ld;
        fetch    = f;
        rom_read = rd;
        ad_sel   = as;
        rom_data = d;
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        int exp_addr;
        exp_addr = ad_sel ? ((m_hi % 16) * 256 + m_lo) : m_pc;
        chk({tag, ".pc"},   int'(pc),      m_pc);
        chk({tag, ".ins"},  int'(ins),     m_hi / 16);
        chk({tag, ".word"}, int'(ir_word), m_hi * 256 + m_lo);
        chk({tag, ".addr"}, int'(addr),    exp_addr);
`ifdef PC_OVF_EN
        chk({tag, ".ovf"},  int'(pc_ovf),  m_ovf);
`endif
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        drive(v.en, v.ld, v.f, v.rd, v.as, v.d);
        chk({tag, ".pc"},   int'(pc),      int'(v.e_pc));
        chk({tag, ".ins"},  int'(ins),     int'(v.e_ins));
        chk({tag, ".word"}, int'(ir_word), int'(v.e_word));
        chk({tag, ".addr"}, int'(addr),    int'(v.e_addr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //              en    ld    f      rd    as    d      pc       ins   word      addr
        tbl[0] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h52, 12'h001, 4'h5, 16'h5200, 12'h001};
        tbl[1] = '{1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 8'h34, 12'h002, 4'h5, 16'h5234, 12'h234};
        tbl[2] = '{1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 8'hAA, 12'h002, 4'h5, 16'h5234, 12'h234};
        tbl[3] = '{1'b0, 1'b0, 2'b11, 1'b1, 1'b0, 8'hFF, 12'h002, 4'h5, 16'h5234, 12'h002};
        tbl[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'hA3, 12'h003, 4'hA, 16'hA334, 12'h003};
        tbl[5] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 8'h7C, 12'h37C, 4'hA, 16'hA334, 12'h37C};
        tbl[6] = '{1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 8'h11, 12'h37C, 4'hA, 16'hA334, 12'h37C};
        tbl[7] = '{1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 8'h11, 12'h311, 4'hA, 16'hA334, 12'h311};
        tbl[8] = '{1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 8'h56, 12'h311, 4'hA, 16'hA356, 12'h356};
        tbl[9] = '{1'b0, 1'b0, 2'b10, 1'b1, 1'b1, 8'h78, 12'h311, 4'hA, 16'hA378, 12'h378};

        // NOP @0, LDO 0x12/0x34 @1-2, data read @0x234, JMP 0x85 @3 with target byte 0x67 @4
        prog[0] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h00, 12'h001, 4'h0, 16'h0000, 12'h001};
        prog[1] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h12, 12'h002, 4'h1, 16'h1200, 12'h002};
        prog[2] = '{1'b1, 1'b0, 2'b10, 1'b1, 1'b0, 8'h34, 12'h003, 4'h1, 16'h1234, 12'h003};
        prog[3] = '{1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 8'h99, 12'h003, 4'h1, 16'h1234, 12'h234};
        prog[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 8'h85, 12'h004, 4'h8, 16'h8534, 12'h004};
        prog[5] = '{1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 8'h67, 12'h567, 4'h8, 16'h8534, 12'h567};

        PC_en = 0; pc_in = 0; fetch = 2'b00; rom_read = 0; ad_sel = 0; rom_data = 8'h00;
        do_reset();
        #1;
        chk("reset.pc",   int'(pc),      0);
        chk("reset.ins",  int'(ins),     0);
        chk("reset.word", int'(ir_word), 0);
        chk("reset.addr", int'(addr),    0);
`ifdef PC_OVF_EN
        chk("reset.ovf",  int'(pc_ovf),  0);
`endif

        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("tbl%0d", i));

        // asynchronous reset mid-instruction with pc=0x123
        drive(1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'h01);
        drive(1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 8'h23);
        chk("pre_rst.pc", int'(pc), 12'h123);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst.pc",   int'(pc),      0);
        chk("async_rst.ins",  int'(ins),     0);
        chk("async_rst.word", int'(ir_word), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // PC at the top of the address space
        drive(1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 8'h0F);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'hFF);
        chk("top.pc", int'(pc), 12'hFFF);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
`ifdef PC_OVF_EN
        chk("ovf.pc",  int'(pc),     12'hFFF);
        chk("ovf.flag", int'(pc_ovf), 1);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        chk("ovf_hold.pc", int'(pc), 12'hFFF);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 8'h10);
        chk("ovf_load.pc",  int'(pc),     12'hF10);
        chk("ovf_sticky",   int'(pc_ovf), 1);
`else
        chk("wrap.pc", int'(pc), 12'h000);
        drive(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 8'h00);
        chk("wrap_next.pc", int'(pc), 12'h001);
`endif

        // small program run as the controller would sequence it
        do_reset();
        foreach (prog[i]) apply_vec(prog[i], $sformatf("prog%0d", i));

        // randomized run against the reference model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [1:0] f;
            logic [7:0] d;
            f = 2'($urandom_range(0, 3));
            d = 8'($urandom);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), f,
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), d);
            check_model($sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
